serial_mac: RTL



---
 rtl/serial_mac_pkg.sv | 24 ++
 rtl/serial_mult_core.sv | 75 +++++++
 rtl/serial_mac.sv | 121 ++++++++++++
 3 files changed

// File: rtl/serial_mac_pkg.sv
// serial_mac_pkg: FSM state encodings, default sizing and configuration check
// shared by the serial multiply-accumulate stage.
`default_nettype none

package serial_mac_pkg;

  typedef enum logic [1:0] {
    SMAC_IDLE = 2'd0,
    SMAC_MUL  = 2'd1,
    SMAC_ACC  = 2'd2,
    SMAC_HOLD = 2'd3
  } smac_state_t;

  localparam int SMAC_DEF_WIDTH     = 8;
  localparam int SMAC_DEF_ACC_WIDTH = 20;

  // The accumulator must hold at least one full product without truncation.
  function automatic bit smac_cfg_ok(input int width, input int acc_width);
    return (width >= 2) && (width <= 16) && (acc_width >= 2 * width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_mult_core.sv
// serial_mult_core: one-bit-per-cycle shift-add unsigned multiplier with
// operand latches, bit counter, product register and a one-cycle done pulse.
`default_nettype none

module serial_mult_core #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    prod_d = prod_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      a_d    = a;
      b_d    = b;
      prod_d = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (b_q[cnt_q]) begin
        prod_d = prod_q + ({{WIDTH{1'b0}}, a_q} << cnt_q);
      end
      cnt_d = cnt_q + 1'b1;
      // Every bit is visited even for zero operands, so latency is fixed.
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      prod_q <= prod_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign product = prod_q;
  assign done    = done_q;

endmodule

`default_nettype wire

// File: rtl/serial_mac.sv
// serial_mac: framed multiply-accumulate with valid/ready in and out.
// Define SERIAL_MAC_SAT_EN to saturate the accumulator instead of wrapping.
`default_nettype none

module serial_mac
  import serial_mac_pkg::*;
#(
  parameter int WIDTH     = SMAC_DEF_WIDTH,
  parameter int ACC_WIDTH = SMAC_DEF_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_ovf
);

  generate
    if (!smac_cfg_ok(WIDTH, ACC_WIDTH)) begin : g_cfg_err
      $error("serial_mac: illegal WIDTH/ACC_WIDTH combination");
    end
  endgenerate

  smac_state_t            state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic                   last_q, last_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   mul_start;
  logic                   mul_done;
  logic [2*WIDTH-1:0]     product;
  logic [ACC_WIDTH:0]     sum_ext;

  serial_mult_core #(
    .WIDTH (WIDTH)
  ) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (in_a),
    .b       (in_b),
    .product (product),
    .done    (mul_done)
  );

  // One extra bit captures the carry out of the accumulator.
  assign sum_ext = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - 2 * WIDTH){1'b0}}, product};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    last_d    = last_q;
    mul_start = 1'b0;
    case (state_q)
      SMAC_IDLE: begin
        if (in_valid) begin
          mul_start = 1'b1;
          last_d    = in_last;
          state_d   = SMAC_MUL;
        end
      end
      SMAC_MUL: begin
        if (mul_done) state_d = SMAC_ACC;
      end
      SMAC_ACC: begin
        ovf_d = ovf_q | sum_ext[ACC_WIDTH];
`ifdef SERIAL_MAC_SAT_EN
        acc_d = ovf_d ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
`else
        acc_d = sum_ext[ACC_WIDTH-1:0];
`endif
        state_d = last_q ? SMAC_HOLD : SMAC_IDLE;
      end
      SMAC_HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = SMAC_IDLE;
        end
      end
      default: state_d = SMAC_IDLE;
    endcase
    // Handshake outputs come from flops, keeping valid/ready paths registered.
    in_ready_d  = (state_d == SMAC_IDLE);
    out_valid_d = (state_d == SMAC_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SMAC_IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

`default_nettype wire
